// File: rtl/conc_trace_recorder.sv
// Trace recorder: run-length compresses a sampled DUT output vector into
// {stamp, value} change records and buffers them in a FWFT FIFO.
module conc_trace_recorder #(
  parameter int SW    = 3,
  parameter int CW    = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic [SW-1:0]            sample,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [CW+SW-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = CW + SW;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic            w_first;
  logic [CW-1:0]   r_cyc;
  logic [SW-1:0]   r_last;
  logic [RW-1:0]   r_mem [DEPTH];
  logic [AW:0]     r_wr;
  logic [AW:0]     r_rd;
  logic [AW:0]     r_count;
  logic            r_valid;
  logic            r_ovf;
  logic [7:0]      r_drop;
  logic [RW-1:0]   r_data;
  logic            w_gen;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_solo;
  logic [RW-1:0]   w_rec;
  logic [AW:0]     w_rd_nx;
  logic [AW:0]     w_count_nx;

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Any cycle with en low re-arms, so the next sampled cycle records.
  always_comb begin
    w_state_nx = r_state;
    if (!en) w_state_nx = S_IDLE;
    else     w_state_nx = S_RUN;
  end

  always_comb begin
    w_first = 1'b0;
    case (r_state)
      S_IDLE:  w_first = 1'b1;
      default: w_first = 1'b0;
    endcase
  end

  assign w_rec  = {r_cyc, sample};
  assign w_gen  = en && (w_first || (sample != r_last) || (r_cyc == '0));
  assign w_pop  = r_valid && rd_ready;
  assign w_push = w_gen && (!r_count[AW] || w_pop);
  assign w_drop = w_gen && !w_push;

  assign w_rd_nx    = r_rd + (AW+1)'(w_pop);
  assign w_count_nx = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  // New record becomes head when it lands in an empty (or emptying) FIFO.
  assign w_solo = (r_count == '0) ||
                  (w_pop && (r_count == (AW+1)'(1)));

  always_ff @(posedge clock) begin
    if (reset && w_push) r_mem[r_wr[AW-1:0]] <= w_rec;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cyc   <= '0;
      r_last  <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
      r_data  <= '0;
    end else begin
      if (en) begin
        r_cyc  <= r_cyc + 1'b1;
        r_last <= sample;
      end
      if (w_push) r_wr <= r_wr + 1'b1;
      r_rd    <= w_rd_nx;
      r_count <= w_count_nx;
      r_valid <= (w_count_nx != '0);
      if (w_push && w_solo) r_data <= w_rec;
      else if (w_pop)       r_data <= r_mem[w_rd_nx[AW-1:0]];
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
      end
    end
  end

  assign rd_valid = r_valid;
  assign rd_data  = r_data;
  assign count    = r_count;
  assign overflow = r_ovf;
  assign drop_cnt = r_drop;
endmodule

// File: tb/tb_conc_trace_recorder.sv
// Bench for conc_trace_recorder (CW=4, DEPTH=4): directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_conc_trace_recorder;
  localparam int SW = 3;
  localparam int CW = 4;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [2:0] sample = '0;
  logic       rd_ready = 1'b0;
  logic       rd_valid;
  logic [6:0] rd_data;
  logic [2:0] count;
  logic       overflow;
  logic [7:0] drop_cnt;

  int n_chk = 0;
  int n_pass = 0;
  logic [6:0] got[$];

  conc_trace_recorder #(.SW(SW), .CW(CW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .en(en), .sample(sample),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  // Reference model: record queue plus the cycle/last/first bookkeeping.
  logic [6:0] m_q[$];
  int         m_cyc = 0;
  logic [2:0] m_last = '0;
  bit         m_first = 1'b1;
  bit         m_ovf = 1'b0;
  int         m_drop = 0;
  bit         m_pop;
  bit         m_gen;
  logic [6:0] m_rec;

  always @(posedge clock) begin
    if (!reset) begin
      m_q.delete();
      m_cyc = 0;
      m_last = '0;
      m_first = 1'b1;
      m_ovf = 1'b0;
      m_drop = 0;
    end else begin
      m_pop = (m_q.size() != 0) && rd_ready;
      m_gen = 1'b0;
      m_rec = '0;
      if (en) begin
        m_gen = m_first || (sample != m_last) || (m_cyc == 0);
        m_rec = {4'(m_cyc), sample};
        m_last = sample;
        m_cyc = (m_cyc + 1) % 16;
        m_first = 1'b0;
      end else begin
        m_first = 1'b1;
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_gen) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_rec);
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
  end

  task automatic drive(input logic e, input logic [2:0] s, input logic rr);
    if (reset && rd_valid && rr) got.push_back(rd_data);
    en = e;
    sample = s;
    rd_ready = rr;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 3'b000, 1'b0);
    reset = 1'b1;
    got.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 3'b101, 1'b1);
    drive(1'b1, 3'b011, 1'b1);
    n_chk++;
    if ({rd_valid, count, overflow, drop_cnt, rd_data} !== 19'd0)
      $display("FAIL reset_state: got v=%b c=%0d o=%b d=%0d data=%h want all 0",
               rd_valid, count, overflow, drop_cnt, rd_data);
    else n_pass++;
    reset = 1'b1;
    got.delete();
  endtask

  task automatic test_constant();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'b000, 1'b0);
      n_chk++;
      if (count !== 3'd1 || rd_data !== 7'd0)
        $display("FAIL const_hold: cyc %0d count=%0d data=%h want 1/00", i, count, rd_data);
      else n_pass++;
    end
    drive(1'b1, 3'b001, 1'b0);
    n_chk++;
    if (count !== 3'd2) $display("FAIL const_change: count=%0d want 2", count);
    else n_pass++;
    for (int i = 0; i < 3; i++) drive(1'b0, 3'b001, 1'b1);
    n_chk++;
    if (got.size() != 2 || got[0] !== 7'd0 || got[1] !== 7'd41)
      $display("FAIL const_stamp: n=%0d r0=%h r1=%h want 2/00/29",
               got.size(), got.size() > 0 ? got[0] : 7'h7f,
               got.size() > 1 ? got[1] : 7'h7f);
    else n_pass++;
  endtask

  task automatic test_changes();
    logic [2:0] seq[7] = '{3'b000, 3'b001, 3'b001, 3'b110, 3'b110, 3'b110, 3'b000};
    logic [6:0] exp[4] = '{7'd0, 7'd9, 7'd30, 7'd48};
    do_reset();
    foreach (seq[i]) drive(1'b1, seq[i], 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 3'b000, 1'b1);
    n_chk++;
    if (got.size() != 4) $display("FAIL changes_n: got %0d records want 4", got.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp[i]) $display("FAIL changes_rec%0d: got %h want %h", i, got[i], exp[i]);
      else n_pass++;
    end
    n_chk++;
    if (drop_cnt !== 8'd0 || overflow !== 1'b0)
      $display("FAIL changes_drop: drop=%0d ovf=%b want 0/0", drop_cnt, overflow);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 3'b000, 1'b0);
    n_chk++;
    if (count !== 3'd2 || overflow !== 1'b0)
      $display("FAIL wrap_count: count=%0d ovf=%b want 2/0", count, overflow);
    else n_pass++;
    for (int i = 0; i < 3; i++) drive(1'b0, 3'b000, 1'b1);
    n_chk++;
    if (got.size() != 2 || got[0] !== 7'd0 || got[1] !== 7'd0)
      $display("FAIL wrap_recs: n=%0d want 2 records stamp 0", got.size());
    else n_pass++;
  endtask

  task automatic test_overflow_and_full_pop();
    logic [6:0] exp[4] = '{7'd0, 7'd9, 7'd16, 7'd25};
    do_reset();
    for (int i = 0; i < 7; i++) drive(1'b1, {2'b00, 1'(i % 2)}, 1'b0);
    n_chk++;
    if (count !== 3'd4 || overflow !== 1'b1 || drop_cnt !== 8'd3)
      $display("FAIL ovf_state: count=%0d ovf=%b drop=%0d want 4/1/3",
               count, overflow, drop_cnt);
    else n_pass++;
    drive(1'b1, 3'b001, 1'b1);
    n_chk++;
    if (count !== 3'd4 || drop_cnt !== 8'd3 || rd_data[6:3] !== 4'd1)
      $display("FAIL full_pop_push: count=%0d drop=%0d stamp=%0d want 4/3/1",
               count, drop_cnt, rd_data[6:3]);
    else n_pass++;
    for (int i = 0; i < 5; i++) drive(1'b0, 3'b000, 1'b1);
    n_chk++;
    if (got.size() != 5) $display("FAIL ovf_drain_n: got %0d want 5", got.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_chk++;
      if (got[i] !== exp[i]) $display("FAIL ovf_drain%0d: got %h want %h", i, got[i], exp[i]);
      else n_pass++;
    end
    n_chk++;
    if (got.size() > 4 && got[4] !== 7'd57)
      $display("FAIL ovf_late: got %h want 39", got[4]);
    else n_pass++;
  endtask

  task automatic test_rearm_and_reset();
    do_reset();
    drive(1'b1, 3'b010, 1'b1);
    drive(1'b1, 3'b010, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 3'b010, 1'b1);
    drive(1'b1, 3'b010, 1'b1);
    drive(1'b0, 3'b010, 1'b1);
    n_chk++;
    if (got.size() != 2 || got[0] !== 7'd2 || got[1] !== 7'd18)
      $display("FAIL rearm: n=%0d r1=%h want 2 records 02,12",
               got.size(), got.size() > 1 ? got[1] : 7'h7f);
    else n_pass++;
    for (int i = 0; i < 6; i++) drive(1'b1, {2'b01, 1'(~i % 2)}, 1'b0);
    drive(1'b1, 3'b111, 1'b1);
    reset = 1'b0;
    drive(1'b1, 3'b000, 1'b1);
    n_chk++;
    if (rd_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0 || drop_cnt !== 8'd0)
      $display("FAIL mid_drain_reset: v=%b c=%0d o=%b d=%0d want 0",
               rd_valid, count, overflow, drop_cnt);
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 270; i++) drive(1'b1, 3'(i % 2 + 4), 1'b0);
    n_chk++;
    if (drop_cnt !== 8'd255 || overflow !== 1'b1 || count !== 3'd4)
      $display("FAIL drop_sat: drop=%0d ovf=%b count=%0d want 255/1/4",
               drop_cnt, overflow, count);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [2:0] s = '0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 2) == 0) s = 3'($urandom);
      drive($urandom_range(0, 3) != 0, s, $urandom_range(0, 2) == 0);
      n_chk++;
      if (rd_valid !== (m_q.size() != 0) || count !== 3'(m_q.size()) ||
          overflow !== m_ovf || drop_cnt !== 8'(m_drop) ||
          (m_q.size() != 0 && rd_data !== m_q[0]))
        $display("FAIL random%0d: v=%b c=%0d o=%b d=%0d data=%h want v=%b c=%0d o=%b d=%0d data=%h",
                 i, rd_valid, count, overflow, drop_cnt, rd_data,
                 m_q.size() != 0, m_q.size(), m_ovf, m_drop,
                 m_q.size() != 0 ? m_q[0] : 7'h00);
      else n_pass++;
    end
    reset = 1'b1;
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_constant();
    test_changes();
    test_wrap();
    test_overflow_and_full_pop();
    test_rearm_and_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
